// File: rtl/axi_regbank_pkg.sv
// axi_regbank_pkg
//   Shared definitions for the AXI4-Lite register bank:
//   - RESP_OKAY / RESP_SLVERR : AXI response encodings
//   - addr_lsb(dw)            : number of byte-offset address bits for a bus of width dw
//   - idx_width(aw, dw)       : width of the register index field within the address
package axi_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int idx_width(input int aw, input int dw);
    return aw - addr_lsb(dw);
  endfunction

endpackage

// File: rtl/axi_regbank_if.sv
// axi_regbank_if
//   AXI4-Lite bus bundle (AW, W, B, AR, R channels) between the interconnect
//   and the register bank.
//   Parameters: ADDR_W (byte address width), DATA_W (32 or 64).
//   Modports:   master (interconnect side), slave (register bank side).
interface axi_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi_regbank_hold_reg.sv
// axi_hold_reg
//   Single-entry valid/ready holding register. Captures one beat and keeps it
//   until the consumer pops it.
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     in_valid/in_ready: upstream handshake; ready = empty & ~block & ~rst
//     in_data          : payload captured on handshake
//     block            : stalls acceptance (downstream response still pending)
//     pop              : empties the entry
//     held, data       : entry occupied flag and stored payload
module axi_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             block,
  input  logic             pop,
  output logic             held,
  output logic [WIDTH-1:0] data
);

  // Reset is folded into ready so the channel reads not-ready while in reset.
  assign in_ready = ~held & ~block & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      held <= 1'b1;
      data <= in_data;
    end else if (pop) begin
      held <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_regbank.sv
// axi_regbank
//   AXI4-Lite slave register bank with NUM_REGS registers, each read-write
//   (drives reg_out) or read-only (returns reg_in), selected by RO_MASK.
//   AW and W are accepted independently into single-entry holds; the write
//   commits one cycle after both are held. Reads return one cycle after the
//   AR handshake.
//   Build option: define AXI_REGBANK_SLVERR_EN to answer writes to RO or
//   unimplemented registers, and reads of unimplemented registers, with
//   SLVERR. Without it those accesses complete with OKAY (still ignored /
//   read as zero, no pulses).
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESET : clock, synchronous active-high reset
//     s_axi                    : AXI4-Lite slave bus
//     reg_out                  : RW register contents, reg i at [i*DW +: DW]
//     reg_in                   : status inputs read back for RO registers
//     wr_pulse                 : one-cycle strobe per committed write
//     rd_pulse                 : one-cycle strobe per accepted read
module axi_regbank
  import axi_regbank_pkg::*;
#(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 8,
  parameter int                  NUM_REGS           = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  axi_regbank_if.slave                           s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  output logic [NUM_REGS-1:0]                    rd_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int LSB  = addr_lsb(DW);
  localparam int IDXW = idx_width(AW, DW);

  logic [DW-1:0] regs_q [NUM_REGS];
  logic          bvalid_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;

  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic          commit;

  axi_hold_reg #(.WIDTH(AW)) u_aw_hold (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .in_valid (s_axi.S_AXI_AWVALID),
    .in_ready (s_axi.S_AXI_AWREADY),
    .in_data  (s_axi.S_AXI_AWADDR),
    .block    (bvalid_q),
    .pop      (commit),
    .held     (aw_held),
    .data     (aw_addr)
  );

  axi_hold_reg #(.WIDTH(DW + NB)) u_w_hold (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .in_valid (s_axi.S_AXI_WVALID),
    .in_ready (s_axi.S_AXI_WREADY),
    .in_data  ({s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB}),
    .block    (bvalid_q),
    .pop      (commit),
    .held     (w_held),
    .data     ({w_data, w_strb})
  );

  assign commit = aw_held & w_held & ~bvalid_q;

  // Indices are widened to 32 bits so they compare cleanly against loop counters.
  logic [31:0]   w_idx, ar_idx;
  logic          w_in_range, w_ro, w_ok, ar_in_range, ar_hs;
  logic [DW-1:0] rd_mux;
  logic [1:0]    wr_resp, rd_resp;

  assign w_idx       = 32'(aw_addr[LSB +: IDXW]);
  assign ar_idx      = 32'(s_axi.S_AXI_ARADDR[LSB +: IDXW]);
  assign w_in_range  = w_idx < $unsigned(NUM_REGS);
  assign ar_in_range = ar_idx < $unsigned(NUM_REGS);
  assign w_ok        = w_in_range & ~w_ro;

  assign s_axi.S_AXI_ARREADY = ~rvalid_q & ~S_AXI_ARESET;
  assign ar_hs               = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;

  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_idx == 32'(i)) w_ro = RO_MASK[i];
  end

  // Out-of-range indices match no register, so the mux reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == 32'(i)) rd_mux = RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
  end

`ifdef AXI_REGBANK_SLVERR_EN
  assign wr_resp = w_ok ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = ar_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_ok && w_idx == 32'(i)) begin
            wr_pulse[i] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (w_strb[b]) regs_q[i][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Registers sample pre-commit values, so a same-edge read returns old data.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_pulse <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= rd_mux;
        for (int i = 0; i < NUM_REGS; i++)
          if (ar_in_range && ar_idx == 32'(i)) rd_pulse[i] <= 1'b1;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  assign s_axi.S_AXI_BVALID = bvalid_q;
  assign s_axi.S_AXI_BRESP  = bresp_q;
  assign s_axi.S_AXI_RVALID = rvalid_q;
  assign s_axi.S_AXI_RRESP  = rresp_q;
  assign s_axi.S_AXI_RDATA  = rdata_q;

  // PROT and the byte-offset address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         aw_addr[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_axi_regbank.sv
// tb_axi_regbank
//   Directed bench for axi_regbank with 4 registers, register 3 read-only.
module tb_axi_regbank;
  import axi_regbank_pkg::*;

`ifdef AXI_REGBANK_SLVERR_EN
  localparam logic [1:0] EXP_ERR = RESP_SLVERR;
`else
  localparam logic [1:0] EXP_ERR = RESP_OKAY;
`endif

  logic         clk = 1'b0;
  logic         areset;
  logic [127:0] reg_out, reg_in;
  logic [3:0]   wr_pulse, rd_pulse;
  int           total = 0;
  int           bad   = 0;

  axi_regbank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi_regbank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (8),
    .NUM_REGS           (4),
    .RO_MASK            (4'b1000)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (areset),
    .s_axi        (bus),
    .reg_out      (reg_out),
    .reg_in       (reg_in),
    .wr_pulse     (wr_pulse),
    .rd_pulse     (rd_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AW and W presented together; handshake at E0, commit and BVALID at E1.
  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] eresp, input logic [3:0] epulse);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b0;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk({tag, "_b_early"}, 128'(bus.S_AXI_BVALID), 128'(0));
    tick();
    chk({tag, "_bvalid"}, 128'(bus.S_AXI_BVALID), 128'(1));
    chk({tag, "_bresp"}, 128'(bus.S_AXI_BRESP), 128'(eresp));
    chk({tag, "_wr_pulse"}, 128'(wr_pulse), 128'(epulse));
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk({tag, "_b_done"}, 128'({bus.S_AXI_BVALID, wr_pulse}), 128'(0));
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] edata,
                         input logic [1:0] eresp, input logic [3:0] epulse);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk({tag, "_rvalid_arready"}, 128'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 128'(2'b10));
    chk({tag, "_rdata"}, 128'(bus.S_AXI_RDATA), 128'(edata));
    chk({tag, "_rresp"}, 128'(bus.S_AXI_RRESP), 128'(eresp));
    chk({tag, "_rd_pulse"}, 128'(rd_pulse), 128'(epulse));
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    chk({tag, "_r_done"}, 128'({bus.S_AXI_RVALID, rd_pulse}), 128'(0));
  endtask

  initial begin
    areset = 1'b1;
    reg_in = {32'h12345678, 32'h99999999, 32'h88888888, 32'h77777777};
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(0));
    chk("rst_valid", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
    chk("rst_resp_data", 128'({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}), 128'(0));
    chk("rst_reg_out", reg_out, 128'(0));
    chk("rst_pulses", 128'({wr_pulse, rd_pulse}), 128'(0));
    areset = 1'b0;
    tick();
    chk("idle_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(3'b111));

    // AW+W same cycle to reg 1
    do_write("wr_same", 8'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY, 4'b0010);
    chk("wr_same_reg1", 128'(reg_out[63:32]), 128'(32'hDEADBEEF));

    // W first, AW three cycles later, byte-1 strobe into reg 2
    do_write("wr_reg2", 8'h08, 32'h11223344, 4'hF, RESP_OKAY, 4'b0100);
    bus.S_AXI_WDATA  = 32'hFFFFABFF;
    bus.S_AXI_WSTRB  = 4'h2;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("wfirst_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b10));
    tick(); tick();
    bus.S_AXI_AWADDR  = 8'h08;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_precommit", 128'({bus.S_AXI_BVALID, reg_out[95:64]}), 128'({1'b0, 32'h11223344}));
    tick();
    chk("wfirst_pulse", 128'(wr_pulse), 128'(4'b0100));
    chk("wfirst_reg2", 128'(reg_out[95:64]), 128'(32'h1122AB44));
    for (int k = 0; k < 5; k++) begin
      chk("bhold_state", 128'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}),
          128'(3'b100));
      tick();
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("bhold_release", 128'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}),
        128'(3'b011));
    chk("wfirst_reg1_kept", 128'(reg_out[63:32]), 128'(32'hDEADBEEF));

    // Read-only register 3 and RW read-back
    do_read("rd_ro", 8'h0C, 32'h12345678, RESP_OKAY, 4'b1000);
    do_write("wr_ro", 8'h0C, 32'hFFFFFFFF, 4'hF, EXP_ERR, 4'b0000);
    chk("wr_ro_reg3", 128'(reg_out[127:96]), 128'(0));
    do_read("rd_rw1", 8'h04, 32'hDEADBEEF, RESP_OKAY, 4'b0010);
    do_read("rd_lowbits", 8'h0B, 32'h1122AB44, RESP_OKAY, 4'b0100);

    // Unimplemented index 4
    do_read("rd_oor", 8'h10, 32'h0, EXP_ERR, 4'b0000);
    do_write("wr_oor", 8'h10, 32'hA5A5A5A5, 4'hF, EXP_ERR, 4'b0000);
    chk("wr_oor_regs", reg_out, {32'h0, 32'h1122AB44, 32'hDEADBEEF, 32'h0});

    // Commit and read handshake of reg 0 on the same edge
    bus.S_AXI_AWADDR  = 8'h00;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'h5;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARADDR  = 8'h00;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("same_edge_valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(2'b11));
    chk("same_edge_rdata", 128'(bus.S_AXI_RDATA), 128'(0));
    chk("same_edge_reg0", 128'(reg_out[31:0]), 128'(32'h5));
    chk("same_edge_pulses", 128'({wr_pulse, rd_pulse}), 128'(8'b0001_0001));
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    chk("same_edge_done", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
    do_read("rd_reg0_new", 8'h00, 32'h5, RESP_OKAY, 4'b0001);

    // Zero strobe still pulses, leaves data alone
    do_write("wr_strb0", 8'h00, 32'hFFFFFFFF, 4'h0, RESP_OKAY, 4'b0001);
    chk("wr_strb0_reg0", 128'(reg_out[31:0]), 128'(32'h5));

    // Reset with AW held and R pending
    bus.S_AXI_AWADDR  = 8'h04;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("mid_aw_held", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b01));
    bus.S_AXI_ARADDR  = 8'h04;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("mid_rvalid", 128'(bus.S_AXI_RVALID), 128'(1));
    areset = 1'b1;
    tick();
    chk("mid_rst_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(0));
    chk("mid_rst_valid", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
    chk("mid_rst_reg_out", reg_out, 128'(0));
    areset = 1'b0;
    tick();
    chk("post_rst_ready", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}),
        128'(3'b111));
    // A W alone must not pair with the aborted AW.
    bus.S_AXI_WDATA  = 32'h77;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    tick();
    chk("post_rst_no_commit", 128'({bus.S_AXI_BVALID, wr_pulse, reg_out}), 128'(0));
    bus.S_AXI_AWADDR  = 8'h08;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    tick();
    chk("post_rst_commit", 128'({bus.S_AXI_BVALID, wr_pulse}), 128'(5'b1_0100));
    chk("post_rst_reg2", 128'(reg_out[95:64]), 128'(32'h77));
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    do_read("post_rst_rd", 8'h08, 32'h77, RESP_OKAY, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
